mem_arbiter: RTL and testbench

- Sequencer and arbiter for the single byte-wide unified RAM port, shared by two requesters: instruction fetch (IF, 32-bit reads) and the MEM stage (loads/stores of 1/2/4 bytes).
- Serialises each access into byte cycles and assembles or splits words little-endian.
- Produces per-requester stall requests that the pipeline controller folds into stall[5:0]. The stall[4] hold of the MEM/WB register depends on stallreq_mem.

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_byte_seq.sv | 109 ++++++++++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified byte-wide RAM port arbiter:
// access sizes, sequencer states and grant owners.
package mem_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    // Byte count for a MEM access; the unused size code 3 behaves as a word.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_seq.sv
// Byte sequencer for one RAM transaction: walks the address, splits store
// data into bytes and assembles load bytes little-endian.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; ram_addr holds its last value
// ST_READ  | address phase plus one trailing cycle for the RAM latency
// ST_WRITE | one byte written per cycle
// ST_DONE  | transaction complete for one cycle, data_o valid
module mem_byte_seq
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [2:0]        n_i,
    input  logic              we_i,
    input  logic [31:0]       wdata_i,
    output logic              idle_o,
    output logic              done_o,
    output logic [31:0]       data_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        byte_idx;
    logic              last_addr;

    // Read data lags its address by one cycle, so the captured byte is cnt-1.
    assign byte_idx  = cnt_q[1:0] - 2'd1;
    assign last_addr = (cnt_q + 3'd1) >= n_q;

    // Next-state, counter, address and data assembly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = we_i ? ST_WRITE : ST_READ;
                    cnt_d   = 3'd0;
                    n_d     = n_i;
                    addr_d  = base_i;
                    wdata_d = wdata_i;
                    data_d  = '0;
                end
            end
            ST_READ: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q != 3'd0) data_d[{byte_idx, 3'b000} +: 8] = ram_din_i;
                    if (!last_addr) addr_d = addr_q + ADDR_W'(1);
                    if (cnt_q == n_q) state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q + 3'd1;
                if (last_addr) state_d = ST_DONE;
                else           addr_d  = addr_q + ADDR_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            n_q     <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    assign idle_o     = (state_q == ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign data_o     = data_q;
    assign ram_addr_o = addr_q;
    assign ram_we_o   = (state_q == ST_WRITE);
    assign ram_dout_o = ram_we_o ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single byte-wide RAM port shared by instruction fetch and
// the MEM stage. Grants in idle only, routes done/data back to the owner and
// handles branch flushes of in-flight fetches.
// Optional: define MEM_ARB_RR_EN for round-robin on ties (MEM priority otherwise).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    input  logic              if_flush_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o
);

    owner_e            owner_q;
    logic              load_q;
    logic [31:0]       if_data_q, mem_rdata_q;
    logic              if_ok, grant_mem, start, abort;
    logic              seq_idle, seq_done, mem_ld_done;
    logic [31:0]       seq_data;
    logic [ADDR_W-1:0] base;
    logic [2:0]        n;
    logic              unused_addr_bits;

    // A flush in idle hides the fetch request for that cycle.
    assign if_ok = if_req_i & ~if_flush_i;

`ifdef MEM_ARB_RR_EN
    owner_e last_q;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        grant_mem = mem_req_i & (~if_ok | (last_q == OWN_IF));
    end

    // Last-grant flag starts at IF so MEM wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    last_q <= OWN_IF;
        else if (start) last_q <= grant_mem ? OWN_MEM : OWN_IF;
    end
`else
    assign grant_mem = mem_req_i;
`endif

    assign start = seq_idle & (mem_req_i | if_ok);
    assign base  = grant_mem ? mem_addr_i[ADDR_W-1:0] : if_addr_i[ADDR_W-1:0];
    assign n     = grant_mem ? size_to_n(mem_size_i) : 3'd4;
    assign abort = (owner_q == OWN_IF) & if_flush_i;
    assign unused_addr_bits = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

    // Latch the owner and whether a MEM grant is a load on acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_IF;
            load_q  <= 1'b0;
        end else if (start) begin
            owner_q <= grant_mem ? OWN_MEM : OWN_IF;
            load_q  <= grant_mem & ~mem_we_i;
        end
    end

    mem_byte_seq #(.ADDR_W(ADDR_W)) u_seq (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start),
        .abort_i    (abort),
        .base_i     (base),
        .n_i        (n),
        .we_i       (grant_mem & mem_we_i),
        .wdata_i    (mem_wdata_i),
        .idle_o     (seq_idle),
        .done_o     (seq_done),
        .data_o     (seq_data),
        .ram_addr_o (ram_addr_o),
        .ram_we_o   (ram_we_o),
        .ram_dout_o (ram_dout_o),
        .ram_din_i  (ram_din_i)
    );

    assign if_done_o   = seq_done & (owner_q == OWN_IF) & ~if_flush_i;
    assign mem_done_o  = seq_done & (owner_q == OWN_MEM);
    assign mem_ld_done = mem_done_o & load_q;

    // Returned data is visible in the done cycle, then held until the next one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            if (if_done_o)   if_data_q   <= seq_data;
            if (mem_ld_done) mem_rdata_q <= seq_data;
        end
    end

    assign if_data_o      = if_done_o   ? seq_data : if_data_q;
    assign mem_rdata_o    = mem_ld_done ? seq_data : mem_rdata_q;
    assign stallreq_if_o  = if_req_i  & ~if_done_o;
    assign stallreq_mem_o = mem_req_i & ~mem_done_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level schedule of expected
// RAM-port activity and completions is checked every cycle, plus literal pins.
module tb_mem_arbiter;

    localparam int AW = 17;
    localparam int NC = 2048;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_flush, mem_req, mem_we;
    logic [31:0]   if_addr, mem_addr, mem_wdata;
    logic [1:0]    mem_size;
    logic          if_done, mem_done, ram_we, stallreq_if, stallreq_mem;
    logic [31:0]   if_data, mem_rdata;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din = 8'h00;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_done_o(if_done), .if_data_o(if_data),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_size_i(mem_size),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_done_o(mem_done), .mem_rdata_o(mem_rdata),
        .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_dout_o(ram_dout),
        .ram_din_i(ram_din),
        .stallreq_if_o(stallreq_if), .stallreq_mem_o(stallreq_mem)
    );

    // RAM model: unwritten bytes read as a pattern of their address
    logic [7:0] ram [int];
    function automatic logic [7:0] rd(input int a);
        if (ram.exists(a)) return ram[a];
        return 8'(a ^ 32'h5A);
    endfunction
    always @(posedge clk) begin
        ram_din <= rd(int'(ram_addr));
        if (ram_we) ram[int'(ram_addr)] = ram_dout;
    end

    int cyc = 0, nvec = 0, nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected events per cycle
    bit            exp_av [NC];
    logic [AW-1:0] exp_a  [NC];
    bit            exp_we [NC];
    logic [7:0]    exp_do [NC];
    bit            exp_ifd[NC];
    bit            exp_memd[NC];
    bit            exp_ld [NC];
    logic [31:0]   exp_dat[NC];

    // Transaction accepted in c0: C1..Cn address phase, done n+2 (read) / n+1 (write).
    // abort_k > 0: only the first abort_k address cycles happen and no done.
    task automatic sched(input int c0, input bit own_mem, input logic [31:0] addr,
                         input int n, input bit we, input logic [31:0] wdata,
                         input int abort_k, output int dc);
        logic [31:0] d;
        int last;
        d = '0;
        last = (abort_k > 0 && abort_k < n) ? abort_k : n;
        for (int k = 1; k <= last; k++) begin
            exp_av[c0+k] = 1'b1;
            exp_a[c0+k]  = AW'(addr + 32'(k) - 32'd1);
            if (we) begin
                exp_we[c0+k] = 1'b1;
                exp_do[c0+k] = wdata[8*(k-1) +: 8];
            end
        end
        for (int k = 0; k < n; k++) d[8*k +: 8] = rd(int'(AW'(addr + 32'(k))));
        dc = -1;
        if (abort_k == 0) begin
            dc = we ? c0 + n + 1 : c0 + n + 2;
            if (own_mem) begin
                exp_memd[dc] = 1'b1;
                exp_ld[dc]   = !we;
            end else begin
                exp_ifd[dc] = 1'b1;
            end
            exp_dat[dc] = d;
        end
    endtask

    // Per-cycle compare against the schedule
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_if = '0, m_mem = '0;
    int obs_ifd = 0, obs_memd = 0, obs_ifd_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_addr = '0; m_if = '0; m_mem = '0;
            chk("rst_ram_addr", 32'(ram_addr), 32'd0);
            chk("rst_ram_we", 32'(ram_we), 32'd0);
            chk("rst_ram_dout", 32'(ram_dout), 32'd0);
            chk("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
            chk("rst_if_data", if_data, 32'd0);
            chk("rst_mem_rdata", mem_rdata, 32'd0);
            chk("rst_stallreq", {30'd0, stallreq_if, stallreq_mem}, {30'd0, if_req, mem_req});
        end else begin
            if (exp_av[cyc]) m_addr = exp_a[cyc];
            if (exp_ifd[cyc]) m_if = exp_dat[cyc];
            if (exp_memd[cyc] && exp_ld[cyc]) m_mem = exp_dat[cyc];
            chk("ram_addr", 32'(ram_addr), 32'(m_addr));
            chk("ram_we", 32'(ram_we), 32'(exp_we[cyc]));
            if (exp_we[cyc]) chk("ram_dout", 32'(ram_dout), 32'(exp_do[cyc]));
            chk("if_done", 32'(if_done), 32'(exp_ifd[cyc]));
            chk("mem_done", 32'(mem_done), 32'(exp_memd[cyc]));
            chk("if_data", if_data, m_if);
            chk("mem_rdata", mem_rdata, m_mem);
            chk("stallreq_if", 32'(stallreq_if), 32'(if_req & ~exp_ifd[cyc]));
            chk("stallreq_mem", 32'(stallreq_mem), 32'(mem_req & ~exp_memd[cyc]));
        end
        if (if_done) begin obs_ifd = cyc; obs_ifd_cnt++; end
        if (mem_done) obs_memd = cyc;
    end

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_idle(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        bit          we;
        logic [31:0] wdata;
    } mreq_t;

    logic [31:0] ifq[$];
    mreq_t       mq[$];
    bit          last_mem = 1'b0;
    int          first_c0 = 0;

    task automatic push_mem(input logic [31:0] a, input logic [1:0] s, input bit we,
                            input logic [31:0] wd);
        mreq_t m;
        m.addr = a; m.size = s; m.we = we; m.wdata = wd;
        mq.push_back(m);
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    task automatic set_reqs();
        if_req  = (ifq.size() > 0);
        mem_req = (mq.size() > 0);
        if (ifq.size() > 0) if_addr = ifq[0];
        if (mq.size() > 0) begin
            mem_addr = mq[0].addr; mem_size = mq[0].size;
            mem_we = mq[0].we; mem_wdata = mq[0].wdata;
        end
    endtask

    // Requesters keep their requests up and advance on their own done edge.
    task automatic run_seq(input int ng);
        int c0, dc;
        bit wm;
        tick();
        set_reqs();
        c0 = cyc;
        first_c0 = cyc;
        for (int g = 0; g < ng; g++) begin
            if (mq.size() > 0 && ifq.size() > 0) begin
`ifdef MEM_ARB_RR_EN
                wm = !last_mem;
`else
                wm = 1'b1;
`endif
            end else begin
                wm = (mq.size() > 0);
            end
            if (wm) sched(c0, 1'b1, mq[0].addr, nbytes(mq[0].size), mq[0].we, mq[0].wdata, 0, dc);
            else    sched(c0, 1'b0, ifq[0], 4, 1'b0, 32'd0, 0, dc);
            last_mem = wm;
            while (cyc < dc) tick();
            tick();
            if (wm) void'(mq.pop_front());
            else    void'(ifq.pop_front());
            if (g == ng - 1) begin
                if_req = 1'b0; mem_req = 1'b0;
            end else begin
                set_reqs();
            end
            c0 = cyc;
        end
        ifq.delete();
        mq.delete();
    endtask

    initial begin
        int c0, c3, dc, cnt0;
        rst_n = 1'b0;
        if_req = 0; if_flush = 0; mem_req = 0; mem_we = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_size = 0;
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h00; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h93;
        ram[32'h2000] = 8'h01; ram[32'h2001] = 8'h02; ram[32'h2002] = 8'h03; ram[32'h2003] = 8'h04;
        ram[32'h10] = 8'h80;
        ram[32'h1FFFE] = 8'hAA; ram[32'h1FFFF] = 8'hBB; ram[32'h0] = 8'hCC; ram[32'h1] = 8'hDD;
        run_idle(3);
        rst_n = 1'b1;
        run_idle(2);

        // word fetch
        ifq.push_back(32'h1000);
        run_seq(1);
        run_idle(2);
        chk("t1_if_data", if_data, 32'h93000013);
        chk("t1_done_cycle", 32'(obs_ifd - first_c0), 32'd6);

        // flush in C2 of a fetch, new fetch accepted in C3
        tick();
        if_req = 1'b1; if_addr = 32'h1100; c0 = cyc;
        sched(c0, 1'b0, 32'h1100, 4, 1'b0, 32'd0, 2, dc);
        tick(); tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0; if_addr = 32'h2000; c3 = cyc;
        sched(c3, 1'b0, 32'h2000, 4, 1'b0, 32'd0, 0, dc);
        while (cyc < dc) tick();
        tick();
        if_req = 1'b0; last_mem = 1'b0;
        run_idle(2);
        chk("t2_if_data", if_data, 32'h04030201);
        chk("t2_done_cycle", 32'(obs_ifd - c3), 32'd6);

        // half-word store
        push_mem(32'h2002, 2'd1, 1'b1, 32'hDEADBEEF);
        run_seq(1);
        run_idle(1);
        chk("t3_byte0", 32'(rd(32'h2002)), 32'hEF);
        chk("t3_byte1", 32'(rd(32'h2003)), 32'hBE);
        chk("t3_done_cycle", 32'(obs_memd - first_c0), 32'd3);

        // simultaneous requests
        ifq.push_back(32'h1000);
        push_mem(32'h10, 2'd0, 1'b0, 32'd0);
        run_seq(2);
        run_idle(2);
        chk("t4_mem_rdata", mem_rdata, 32'h00000080);
        chk("t4_if_data", if_data, 32'h93000013);
`ifndef MEM_ARB_RR_EN
        chk("t4_mem_done_cycle", 32'(obs_memd - first_c0), 32'd3);
        chk("t4_if_done_cycle", 32'(obs_ifd - first_c0), 32'd10);
`endif

        // address wrap, truncation and size code 3
        push_mem(32'h0001FFFE, 2'd3, 1'b0, 32'd0);
        run_seq(1);
        run_idle(1);
        chk("t5_wrap_word", mem_rdata, 32'hDDCCBBAA);
        push_mem(32'hFFFFFFFF, 2'd1, 1'b0, 32'd0);
        run_seq(1);
        run_idle(1);
        chk("t5_wrap_half", mem_rdata, 32'h0000CCBB);

        // flush in idle suppresses acceptance for that cycle
        tick();
        if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h1000;
        tick();
        if_flush = 1'b0; c0 = cyc;
        sched(c0, 1'b0, 32'h1000, 4, 1'b0, 32'd0, 0, dc);
        while (cyc < dc) tick();
        tick();
        if_req = 1'b0; last_mem = 1'b0;
        run_idle(1);
        chk("t6_done_cycle", 32'(obs_ifd - c0), 32'd6);

        // flush in the done cycle drops that completion
        cnt0 = obs_ifd_cnt;
        tick();
        if_req = 1'b1; if_addr = 32'h1004; c0 = cyc;
        sched(c0, 1'b0, 32'h1004, 4, 1'b0, 32'd0, 99, dc);
        while (cyc < c0 + 6) tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0; c3 = cyc;
        sched(c3, 1'b0, 32'h1004, 4, 1'b0, 32'd0, 0, dc);
        while (cyc < dc) tick();
        tick();
        if_req = 1'b0;
        run_idle(1);
        chk("t7_if_done_count", 32'(obs_ifd_cnt - cnt0), 32'd1);

        // reset in C3 of a word write
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2;
        mem_addr = 32'h3000; mem_wdata = 32'h11223344; c0 = cyc;
        sched(c0, 1'b1, 32'h3000, 4, 1'b1, 32'h11223344, 2, dc);
        tick(); tick(); tick();
        rst_n = 1'b0; mem_req = 1'b0;
        #1;
        chk("t8_rst_we", 32'(ram_we), 32'd0);
        chk("t8_rst_addr", 32'(ram_addr), 32'd0);
        tick(); tick();
        rst_n = 1'b1; last_mem = 1'b0;
        run_idle(4);
        chk("t8_byte0", 32'(rd(32'h3000)), 32'h44);
        chk("t8_no_write", 32'(rd(32'h3002)), 32'h58);

        // both requesters continuously busy
        cnt0 = obs_ifd_cnt;
        for (int i = 0; i < 4; i++) begin
            ifq.push_back(32'h1000 + 32'(16 * i));
            push_mem(32'h10 + 32'(i), 2'd0, 1'b0, 32'd0);
        end
        run_seq(4);
        run_idle(2);
`ifdef MEM_ARB_RR_EN
        chk("t9_if_grants", 32'(obs_ifd_cnt - cnt0), 32'd2);
        chk("t9_mem_rdata", mem_rdata, 32'h0000004B);
`else
        chk("t9_if_grants", 32'(obs_ifd_cnt - cnt0), 32'd0);
        chk("t9_mem_rdata", mem_rdata, 32'h00000049);
`endif

        run_idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
